uart_tx_dev: RTL
================

// Module: uart_tx_dev
// PURPOSE
//  Memory-mapped UART transmitter. Attaches to the Bridge as a third device, next to timer0/timer1.
//  Consumes Bridge device-side write data. Returns read data and a level IRQ that the Bridge folds into HWInt.
//  Buffers CPU bytes in a small FIFO and serialises them as 8N1 frames, LSB first, on TxD.
// PARAMETERS
//  FIFO_DEPTH  4       FIFO entries; power of two, 2..16
//  BAUD_RST    16'd433 reset value of BAUD register; each bit lasts BAUD+1 clk cycles
// PORTS
//  clk      in   1   system clock; all state updates on rising edge
//  reset    in   1   synchronous, active-low: state clears on a rising clk edge while reset==0
//  Addr     in   2   Bridge Dev_Addr[3:2]: register select
//  WE       in   1   write enable from Bridge (already qualified by device hit)
//  DataIn   in   32  write data from Bridge
//  DataOut  out  32  register read data, combinational from Addr
//  IRQ      out  1   level interrupt to Bridge
//  TxD      out  1   serial output, idle high
// BEHAVIOUR
//  Register map (Addr):
//   0 CTRL    [0]=EN, [1]=IE; other bits read 0; reset 0.
//   1 BAUD    [15:0]; reset BAUD_RST; [31:16] read 0.
//   2 TXDATA  write pushes DataIn[7:0]; read returns 0.
//   3 STATUS  read-only except OVF:
//             [0]=BUSY (FSM!=IDLE), [1]=FULL, [2]=EMPTY, [3]=OVF (sticky),
//             [8:4]=FIFO count; any write to addr 3 clears OVF.
//  Reset: TxD=1, IRQ=0, FIFO empty, count 0, OVF=0, FSM=IDLE, CTRL=0, BAUD=BAUD_RST.
//   Reset mid-frame aborts the frame; TxD=1 on the next cycle.
//  Writes take effect at the clk edge where WE=1. DataOut is pure combinational on Addr/state.
//  FIFO:
//   - Push when WE && Addr==2.
//   - FULL is sampled before the edge: a push while FULL is dropped and sets OVF,
//     even if a pop occurs in the same cycle.
//   - A push and a pop in the same cycle when not full leave count unchanged.
//   - Read/write pointers wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, START, DATA, STOP.
//   - IDLE: TxD=1. If EN && !EMPTY: pop head into shift reg, latch BAUD into div, clear baud_cnt, go START.
//   - START: TxD=0 for div+1 cycles, then go DATA with bit_idx=0.
//   - DATA: TxD=shift[0] for div+1 cycles, then shift right and bit_idx++. After bit 7, go STOP.
//   - STOP: TxD=1 for div+1 cycles. Then, if EN && !EMPTY, pop and go START directly
//     (back-to-back frames, no idle gap); else go IDLE.
//   - Latency: a push into an empty FIFO with EN=1 and FSM idle pops on the next edge;
//     TxD falls 1 cycle after that edge (registered output).
//   - Frame length = 10*(div+1) cycles.
//  Counters:
//   - baud_cnt is 16 bits and counts 0..div.
//   - BAUD writes mid-frame do not affect the current frame (div latched at pop).
//   - BAUD=0 gives 1 cycle per bit.
//  EN cleared mid-frame: the current frame completes, no further pops; FIFO contents are retained.
//  IRQ = IE && EMPTY && FSM==IDLE, registered (1-cycle lag). It deasserts when IE is cleared or a byte is pushed.
// TESTING
//  1. Hold reset=0 for 3 cycles -> TxD=1, IRQ=0; STATUS reads 0x0000_0004; BAUD reads 433.
//  2. BAUD=3, CTRL=1, write TXDATA=0x55 -> TxD: 0, then 1,0,1,0,1,0,1,0, then 1;
//     each level 4 cycles, 40 cycles total; BUSY=0 afterwards.
//  3. BAUD=1, CTRL=0, push 0x01,0x02,0x03,0x04,0x05 -> count=4, FULL=1, OVF=1;
//     write STATUS clears OVF. Set CTRL=1 -> 4 back-to-back 20-cycle frames, no idle gap.
//  4. CTRL=3, push 0xA5 -> IRQ drops within 1 cycle of the push and rises 1 cycle after the
//     STOP bit ends. Clearing IE drops IRQ.
//  5. Mid-DATA (bit 3) of a BAUD=3 frame: write BAUD=7 -> the current frame keeps 4-cycle bits;
//     the next frame uses 8-cycle bits.
//  6. Mid-frame reset=0 for 1 cycle -> TxD=1 next cycle, FIFO empty, FSM IDLE, CTRL=0.

Source files
------------

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter for the Bridge: CTRL/BAUD/TXDATA/STATUS registers,
// a small byte FIFO, and a registered TxD/IRQ driven by a four-state frame FSM.
module uart_tx_dev #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RST   = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        IRQ,
    output logic        TxD
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic [15:0]   baud_q, baud_d;
    logic [15:0]   div_q, div_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          txd_q, txd_d;
    logic          irq_q, irq_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          en_s, ie_s, full_s, empty_s, busy_s;
    logic          push_s, push_ok_s, pop_s, bit_end_s, can_pop_s;
    logic [4:0]    cnt5_s;
    logic          unused_s;

    assign en_s      = ctrl_q[0];
    assign ie_s      = ctrl_q[1];
    assign full_s    = (count_q == FULL_CNT);
    assign empty_s   = (count_q == '0);
    assign busy_s    = (state_q != S_IDLE);
    assign push_s    = WE && (Addr == 2'd2);
    assign push_ok_s = push_s && !full_s;
    assign bit_end_s = (baud_cnt_q == div_q);
    assign can_pop_s = en_s && !empty_s;
    assign cnt5_s    = 5'(count_q);
    assign unused_s  = ^DataIn[31:16];

    // Frame sequencing; a pop latches the head byte and the current BAUD divisor.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        baud_cnt_d = baud_cnt_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        pop_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (can_pop_s) begin
                    pop_s      = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    div_d      = baud_q;
                    baud_cnt_d = 16'd0;
                    state_d    = S_START;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end_s) begin
                    baud_cnt_d = 16'd0;
                    if (can_pop_s) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        div_d   = baud_q;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register writes, FIFO bookkeeping and the registered line/IRQ values.
    always_comb begin
        ctrl_d   = ctrl_q;
        baud_d   = baud_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (WE && (Addr == 2'd0)) begin
            ctrl_d = DataIn[1:0];
        end else begin
            ctrl_d = ctrl_q;
        end
        if (WE && (Addr == 2'd1)) begin
            baud_d = DataIn[15:0];
        end else begin
            baud_d = baud_q;
        end
        // FULL is judged before the edge, so a same-cycle pop never rescues a push.
        if (push_s && full_s) begin
            ovf_d = 1'b1;
        end else if (WE && (Addr == 2'd3)) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        case (state_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase
        irq_d = ie_s && empty_s && (state_q == S_IDLE);
    end

    // State and register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 2'd0;
            baud_q     <= BAUD_RST;
            div_q      <= 16'd0;
            baud_cnt_q <= 16'd0;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            txd_q      <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            txd_q      <= txd_d;
            irq_q      <= irq_d;
        end
    end

    // FIFO storage; contents need no reset because count/pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_ok_s && reset) begin
            mem_q[wr_ptr_q] <= DataIn[7:0];
        end
    end

    // Register read mux.
    always_comb begin
        case (Addr)
            2'd0:    DataOut = {30'd0, ctrl_q};
            2'd1:    DataOut = {16'd0, baud_q};
            2'd2:    DataOut = 32'd0;
            2'd3:    DataOut = {23'd0, cnt5_s, ovf_q, empty_s, full_s, busy_s};
            default: DataOut = 32'd0;
        endcase
    end

    assign TxD = txd_q;
    assign IRQ = irq_q;

endmodule
